// File: rtl/pixel_fifo.sv
// pixel_fifo: single-clock first-word-fall-through FIFO for pixel words.
// Pointers are one bit wider than the address so that full and empty can be
// told apart when the addresses match.
// Optional feature macro: PIXEL_FIFO_STATUS_EN adds the count, overflow and
// underflow status outputs.
module pixel_fifo #(
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0]       din,
  output logic                             full,
  input  logic                             rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]       dout,
  output logic                             empty
`ifdef PIXEL_FIFO_STATUS_EN
  ,
  output logic [$clog2(FIFO_BUFFER_SIZE):0] count,
  output logic                             overflow,
  output logic                             underflow
`endif
);

  localparam int ADDR_W = $clog2(FIFO_BUFFER_SIZE);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
  logic [ADDR_W:0]            wr_ptr;
  logic [ADDR_W:0]            rd_ptr;
  logic                       wr_accept;
  logic                       rd_accept;

  // Flags come straight from the registered pointers; an MSB difference with
  // equal address bits means the writer has lapped the reader exactly once.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Requests against a blocking flag are simply not accepted.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Head of queue is always visible, so a consumer pops the word it sees.
  assign dout = mem[rd_ptr[ADDR_W-1:0]];

  // Storage write; contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  // Pointer update; reset wins over any request and discards stored data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef PIXEL_FIFO_STATUS_EN
  // Occupancy follows from the pointer distance, wrapping naturally.
  assign count = wr_ptr - rd_ptr;

  // Sticky error flags that only reset clears.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// tb_pixel_fifo: randomized self-checking bench for pixel_fifo, using a
// queue-based reference model (24-bit words, 16 entries).
module tb_pixel_fifo;

  localparam int W = 24;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  din   = '0;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
`ifdef PIXEL_FIFO_STATUS_EN
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;
`endif

  pixel_fifo #(.FIFO_DATA_WIDTH(W), .FIFO_BUFFER_SIZE(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .din(din),
    .full(full),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty)
`ifdef PIXEL_FIFO_STATUS_EN
    ,
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [W-1:0] model_q[$];
  logic [W-1:0] sent_q[$];
  logic [W-1:0] popped_q[$];
  bit           model_ovf = 1'b0;
  bit           model_udf = 1'b0;
  int           tests = 0;
  int           fails = 0;

  // Compare one observed value with the expected one and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check all outputs against the model after an edge.
  task automatic checkState(input string tag);
    checkOutput({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    checkOutput({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
    if (model_q.size() != 0) begin
      checkOutput({tag, "_dout"}, 32'(dout), 32'(model_q[0]));
    end
`ifdef PIXEL_FIFO_STATUS_EN
    checkOutput({tag, "_count"}, 32'(count), 32'(model_q.size()));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(model_ovf));
    checkOutput({tag, "_underflow"}, 32'(underflow), 32'(model_udf));
`endif
  endtask

  // Drive one cycle of inputs, update the model with the rules of a FIFO,
  // and check the DUT a little after the edge.
  task automatic applyStimulus(input string tag, input bit rst_n, input bit w, input bit r,
                               input logic [W-1:0] d);
    bit wacc;
    bit racc;
    reset = rst_n;
    wr_en = w;
    rd_en = r;
    din   = d;
    #1;
    if (!rst_n) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      wacc = w && (model_q.size() < DEPTH);
      racc = r && (model_q.size() > 0);
      if (w && !wacc) model_ovf = 1'b1;
      if (r && !racc) model_udf = 1'b1;
      if (racc) begin
        checkOutput({tag, "_pop_dout"}, 32'(dout), 32'(model_q[0]));
        popped_q.push_back(dout);
        void'(model_q.pop_front());
      end
      if (wacc) begin
        model_q.push_back(d);
        sent_q.push_back(d);
      end
    end
    @(posedge clock);
    #1;
    checkState(tag);
  endtask

  initial begin
    logic [W-1:0] rd;
    @(negedge clock);

    // Reset held for two cycles, then idle after release
    applyStimulus("rst0", 1'b0, 1'b0, 1'b0, '0);
    applyStimulus("rst1", 1'b0, 1'b0, 1'b0, '0);
    applyStimulus("idle", 1'b1, 1'b0, 1'b0, '0);

    // Single word through the FIFO
    applyStimulus("w555", 1'b1, 1'b1, 1'b0, 24'h555555);
    applyStimulus("p555", 1'b1, 1'b0, 1'b1, '0);

    // Pop from empty is ignored
    applyStimulus("udf", 1'b1, 1'b0, 1'b1, '0);

    // Overfill with 17 words, then drain 16 in order
    for (int i = 1; i <= 17; i++) applyStimulus("fill17", 1'b1, 1'b1, 1'b0, W'(i));
    for (int i = 0; i < 16; i++) applyStimulus("drain16", 1'b1, 1'b0, 1'b1, '0);

    // Fill to full, then simultaneous write and pop
    for (int i = 0; i < 16; i++) applyStimulus("fill", 1'b1, 1'b1, 1'b0, W'(32'h100 + i));
    applyStimulus("fullwr", 1'b1, 1'b1, 1'b1, 24'hABCDEF);
    for (int i = 0; i < 15; i++) applyStimulus("drain", 1'b1, 1'b0, 1'b1, '0);

    // Continuous stream across the pointer wrap
    sent_q.delete();
    popped_q.delete();
    for (int i = 0; i < 40; i++) applyStimulus("stream", 1'b1, 1'b1, 1'b1, W'(32'h2000 + i));
    applyStimulus("stream_end", 1'b1, 1'b0, 1'b1, '0);
    checkOutput("stream_len", 32'(popped_q.size()), 32'd40);
    for (int i = 0; i < popped_q.size() && i < sent_q.size(); i++)
      checkOutput("stream_order", 32'(popped_q[i]), 32'(sent_q[i]));

    // Reset mid-stream with a write pending
    for (int i = 0; i < 5; i++) applyStimulus("hold5", 1'b1, 1'b1, 1'b0, W'(32'h300 + i));
    applyStimulus("rst_wr", 1'b0, 1'b1, 1'b0, 24'h777777);
    applyStimulus("post_rst", 1'b1, 1'b0, 1'b0, '0);

    // Randomized traffic with rare resets
    for (int i = 0; i < 400; i++) begin
      rd = W'($urandom);
      applyStimulus("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) != 0), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
